// File: rtl/dev_stage_pkg.sv
// Shared definitions for the development stage tracker slice.
// Provides the stage width, the named stage encodings and the
// tracker FSM state type used by the top module.
package dev_stage_pkg;

   localparam int STAGE_W = 2;

   localparam logic [STAGE_W-1:0] STAGE_INFANT     = 2'd0;
   localparam logic [STAGE_W-1:0] STAGE_CHILD      = 2'd1;
   localparam logic [STAGE_W-1:0] STAGE_ADOLESCENT = 2'd2;
   localparam logic [STAGE_W-1:0] STAGE_ADULT      = 2'd3;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } tracker_state_e;

endpackage

// File: rtl/dev_stage_age_counter.sv
// Saturating up-counter used for the committed-stage age.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears the count
//   inc_i    advance the count by one (ignored once saturated)
//   clear_i  force the count to zero, wins over inc_i
//   count_o  current registered count
module dev_stage_age_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         clear_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   // Clear dominates so a commit on a tick cycle restarts the age at zero;
   // otherwise count up and stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/development_stage_tracker.sv
// Debounces the raw 2-bit development stage and commits a new stage only
// after it has held for DWELL_TICKS time-base ticks. Emits one-cycle
// advance/regress pulses on commit and tracks the age of the committed stage.
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   tick           one-cycle time-base strobe
//   stage_in       raw stage from the level resource MSBs
//   stage_out      committed stage
//   advance_pulse  one cycle, committed stage went up
//   regress_pulse  one cycle, committed stage went down
//   pending        a candidate stage is being qualified
//   stage_age      ticks since the last commit, saturating
module development_stage_tracker
   import dev_stage_pkg::*;
#(
   parameter int DWELL_TICKS   = 4,
   parameter int CNT_W         = 3,
   parameter int AGE_W         = 8,
   parameter int ALLOW_REGRESS = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic [STAGE_W-1:0] stage_in,
   output logic [STAGE_W-1:0] stage_out,
   output logic               advance_pulse,
   output logic               regress_pulse,
   output logic               pending,
   output logic [AGE_W-1:0]   stage_age
);

   localparam logic [CNT_W:0] DWELL_LIM = (CNT_W+1)'(DWELL_TICKS);

   tracker_state_e     state_q;
   logic [STAGE_W-1:0] stage_q;
   logic [STAGE_W-1:0] cand_q;
   logic [CNT_W-1:0]   dwell_q;
   logic [CNT_W:0]     dwell_d;
   logic               adv_q;
   logic               reg_q;
   logic               eligible;
   logic               commit;

   // A raw stage is worth qualifying when it differs from the committed one;
   // with regression disabled only higher stages count. The dwell increment
   // is one bit wider so the limit compare cannot wrap.
   always_comb begin
      eligible = (stage_in != stage_q) &&
                 ((ALLOW_REGRESS != 0) || (stage_in > stage_q));
      dwell_d  = {1'b0, dwell_q} + (CNT_W+1)'(1);
      commit   = (state_q == ST_PENDING) && eligible && (stage_in == cand_q) &&
                 tick && (dwell_d == DWELL_LIM);
   end

   // Qualification FSM. Abort beats restart beats commit beats counting, so
   // a tick coinciding with an abort or candidate change is never counted.
   // Pulses default low so each lasts exactly the cycle stage_out changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STABLE;
         stage_q <= STAGE_INFANT;
         cand_q  <= STAGE_INFANT;
         dwell_q <= '0;
         adv_q   <= 1'b0;
         reg_q   <= 1'b0;
      end else begin
         adv_q <= 1'b0;
         reg_q <= 1'b0;
         unique case (state_q)
            ST_STABLE: begin
               if (eligible) begin
                  state_q <= ST_PENDING;
                  cand_q  <= stage_in;
                  dwell_q <= '0;
               end
            end
            ST_PENDING: begin
               if (!eligible) begin
                  state_q <= ST_STABLE;
                  dwell_q <= '0;
               end else if (stage_in != cand_q) begin
                  cand_q  <= stage_in;
                  dwell_q <= '0;
               end else if (commit) begin
                  stage_q <= cand_q;
                  state_q <= ST_STABLE;
                  dwell_q <= '0;
                  adv_q   <= (cand_q > stage_q);
                  reg_q   <= (cand_q < stage_q);
               end else if (tick) begin
                  dwell_q <= dwell_d[CNT_W-1:0];
               end
            end
            default: begin
               state_q <= ST_STABLE;
            end
         endcase
      end
   end

   // Age runs on every tick regardless of FSM state and restarts on commit.
   dev_stage_age_counter #(
      .W(AGE_W)
   ) u_age (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (tick),
      .clear_i(commit),
      .count_o(stage_age)
   );

   assign stage_out     = stage_q;
   assign advance_pulse = adv_q;
   assign regress_pulse = reg_q;
   assign pending       = (state_q == ST_PENDING);

endmodule

// File: tb/tb_development_stage_tracker.sv
// Bench for development_stage_tracker. Two instances share stimulus: one
// allowing regression, one forbidding it. A behavioural model per instance
// is compared every cycle, and directed scenarios add literal expectations.
module tb_development_stage_tracker;

   localparam int DWELL   = 4;
   localparam int AGE_MAX = 255;

   typedef struct {
      int stage;
      int cand;
      int ticks;
      int age;
      bit adv;
      bit rg;
   } model_t;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic [1:0] stageIn;
   logic [1:0] dStage [2];
   logic       dAdv   [2];
   logic       dReg   [2];
   logic       dPend  [2];
   logic [7:0] dAge   [2];

   int     checks = 0;
   int     errors = 0;
   model_t mdl [2];

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   development_stage_tracker #(
      .DWELL_TICKS(4), .CNT_W(3), .AGE_W(8), .ALLOW_REGRESS(1)
   ) dutA (
      .clk(clk), .rst_n(rst_n), .tick(tick), .stage_in(stageIn),
      .stage_out(dStage[0]), .advance_pulse(dAdv[0]), .regress_pulse(dReg[0]),
      .pending(dPend[0]), .stage_age(dAge[0])
   );

   development_stage_tracker #(
      .DWELL_TICKS(4), .CNT_W(3), .AGE_W(8), .ALLOW_REGRESS(0)
   ) dutB (
      .clk(clk), .rst_n(rst_n), .tick(tick), .stage_in(stageIn),
      .stage_out(dStage[1]), .advance_pulse(dAdv[1]), .regress_pulse(dReg[1]),
      .pending(dPend[1]), .stage_age(dAge[1])
   );

   // One clock of the tracker rules: cand < 0 means no candidate is held.
   function automatic model_t modelStep(model_t m, int in, bit t, bit allow);
      model_t n;
      bit     elig;
      n     = m;
      n.adv = 1'b0;
      n.rg  = 1'b0;
      elig  = (in != m.stage) && (allow || in > m.stage);
      if (m.cand < 0) begin
         if (elig) begin
            n.cand  = in;
            n.ticks = 0;
         end
      end else if (!elig) begin
         n.cand  = -1;
         n.ticks = 0;
      end else if (in != m.cand) begin
         n.cand  = in;
         n.ticks = 0;
      end else if (t) begin
         n.ticks = m.ticks + 1;
         if (n.ticks == DWELL) begin
            n.stage = m.cand;
            n.cand  = -1;
            n.ticks = 0;
            n.adv   = (m.cand > m.stage);
            n.rg    = (m.cand < m.stage);
         end
      end
      if (n.adv || n.rg) n.age = 0;
      else if (t && m.age < AGE_MAX) n.age = m.age + 1;
      return n;
   endfunction

   function automatic model_t modelReset();
      model_t m;
      m.stage = 0; m.cand = -1; m.ticks = 0; m.age = 0; m.adv = 0; m.rg = 0;
      return m;
   endfunction

   // Model advances on the same edges as the DUT and clears on reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl[0] <= modelReset();
         mdl[1] <= modelReset();
      end else begin
         mdl[0] <= modelStep(mdl[0], int'(stageIn), tick, 1'b1);
         mdl[1] <= modelStep(mdl[1], int'(stageIn), tick, 1'b0);
      end
   end

   task automatic checkField(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Every cycle out of reset, compare both instances to the model.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            checkField($sformatf("model stage inst%0d", i), int'(dStage[i]), mdl[i].stage);
            checkField($sformatf("model adv inst%0d", i), int'(dAdv[i]), int'(mdl[i].adv));
            checkField($sformatf("model reg inst%0d", i), int'(dReg[i]), int'(mdl[i].rg));
            checkField($sformatf("model pend inst%0d", i), int'(dPend[i]), int'(mdl[i].cand >= 0));
            checkField($sformatf("model age inst%0d", i), int'(dAge[i]), mdl[i].age);
         end
      end
   end

   // Drive inputs, then let n edges sample them; returns at posedge+2.
   task automatic applyStimulus(input logic [1:0] s, input logic t, input int n);
      for (int k = 0; k < n; k++) begin
         stageIn = s;
         tick    = t;
         @(posedge clk);
         #2;
      end
   endtask

   // Literal expectations; age < 0 leaves the age unchecked.
   task automatic checkOutput(input int inst, input string name, input int st,
                              input int adv, input int rg, input int pd, input int age);
      checkField({name, " stage"}, int'(dStage[inst]), st);
      checkField({name, " adv"},   int'(dAdv[inst]), adv);
      checkField({name, " reg"},   int'(dReg[inst]), rg);
      checkField({name, " pend"},  int'(dPend[inst]), pd);
      if (age >= 0) checkField({name, " age"}, int'(dAge[inst]), age);
   endtask

   task automatic resetDut();
      stageIn = 2'd0;
      tick    = 1'b0;
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      tick    = 1'b0;
      stageIn = 2'd0;
      #17 rst_n = 1'b1;
      #0;
      checkOutput(0, "reset", 0, 0, 0, 0, 0);
      checkOutput(1, "resetB", 0, 0, 0, 0, 0);

      $display("[TB] async reset during qualification");
      applyStimulus(2'd1, 1'b0, 1);
      checkOutput(0, "entry", 0, 0, 0, 1, 0);
      applyStimulus(2'd1, 1'b1, 2);
      #1 rst_n = 1'b0;
      #1;
      checkOutput(0, "async rst", 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      applyStimulus(2'd1, 1'b0, 1);
      applyStimulus(2'd1, 1'b1, 3);
      checkOutput(0, "post rst 3 ticks", 0, 0, 0, 1, 3);
      applyStimulus(2'd1, 1'b1, 1);
      checkOutput(0, "post rst commit", 1, 1, 0, 0, 0);

      $display("[TB] sparse ticks 0->1");
      resetDut();
      applyStimulus(2'd1, 1'b0, 1);
      checkOutput(0, "sparse entry", 0, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(2'd1, 1'b0, 2);
         applyStimulus(2'd1, 1'b1, 1);
      end
      checkOutput(0, "sparse 3 ticks", 0, 0, 0, 1, 3);
      applyStimulus(2'd1, 1'b0, 2);
      applyStimulus(2'd1, 1'b1, 1);
      checkOutput(0, "sparse commit", 1, 1, 0, 0, 0);
      applyStimulus(2'd1, 1'b0, 1);
      checkOutput(0, "sparse pulse end", 1, 0, 0, 0, 0);

      $display("[TB] glitch abort");
      resetDut();
      applyStimulus(2'd1, 1'b0, 1);
      applyStimulus(2'd1, 1'b1, 3);
      applyStimulus(2'd0, 1'b0, 1);
      checkOutput(0, "glitch abort", 0, 0, 0, 0, 3);
      applyStimulus(2'd1, 1'b0, 1);
      applyStimulus(2'd1, 1'b1, 3);
      checkOutput(0, "glitch 3 new ticks", 0, 0, 0, 1, 6);
      applyStimulus(2'd1, 1'b1, 1);
      checkOutput(0, "glitch commit", 1, 1, 0, 0, 0);

      $display("[TB] regression allowed vs forbidden");
      applyStimulus(2'd2, 1'b0, 1);
      applyStimulus(2'd2, 1'b1, 4);
      checkOutput(0, "to 2 A", 2, 1, 0, 0, 0);
      checkOutput(1, "to 2 B", 2, 1, 0, 0, 0);
      applyStimulus(2'd0, 1'b0, 1);
      checkOutput(1, "drop B idle", 2, 0, 0, 0, 0);
      applyStimulus(2'd0, 1'b1, 3);
      checkOutput(0, "drop A pending", 2, 0, 0, 1, 3);
      applyStimulus(2'd0, 1'b1, 1);
      checkOutput(0, "regress A", 0, 0, 1, 0, 0);
      checkOutput(1, "no regress B", 2, 0, 0, 0, 4);

      $display("[TB] direct jump and age saturation");
      applyStimulus(2'd3, 1'b0, 1);
      applyStimulus(2'd3, 1'b1, 4);
      checkOutput(0, "jump 0->3", 3, 1, 0, 0, 0);
      checkOutput(1, "jump 2->3", 3, 1, 0, 0, 0);
      applyStimulus(2'd3, 1'b1, 300);
      checkOutput(0, "age sat A", 3, 0, 0, 0, 255);
      checkOutput(1, "age sat B", 3, 0, 0, 0, 255);
      applyStimulus(2'd3, 1'b1, 2);
      checkOutput(0, "age hold", 3, 0, 0, 0, 255);

      $display("[TB] candidate switch");
      resetDut();
      applyStimulus(2'd1, 1'b0, 1);
      applyStimulus(2'd1, 1'b1, 2);
      applyStimulus(2'd2, 1'b0, 1);
      checkOutput(0, "switch restart", 0, 0, 0, 1, 2);
      applyStimulus(2'd2, 1'b1, 3);
      checkOutput(0, "switch 3 ticks", 0, 0, 0, 1, 5);
      applyStimulus(2'd2, 1'b1, 1);
      checkOutput(0, "switch commit", 2, 1, 0, 0, 0);
      applyStimulus(2'd2, 1'b0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
